mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester round-robin memory/I-O bus arbiter (optional bus lock: BUS_ARB_LOCK_EN)
module mem_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        io,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef BUS_ARB_LOCK_EN
    input  logic [1:0]        lock,
`endif
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_ri,
    output logic              bus_ro,
    output logic              bus_io,
    output logic              mem_clk
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q;       // requester owning the current transaction
    logic              last_q;      // requester granted most recently (round-robin pointer)
    logic              we_q;
    logic              io_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              rr_sel;      // round-robin winner for the current req vector
    logic              take;        // latch a new transaction on this edge
    logic              take_sel;    // requester being latched

    // Round-robin choice: a lone requester wins, a tie goes to whoever was not granted last
    assign rr_sel = (req == 2'b10) || ((req == 2'b11) && !last_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arbitration happens in IDLE and again in HOLD for back-to-back transfers
    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        take_sel = rr_sel;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_SETUP;
                    take    = 1'b1;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
`ifdef BUS_ARB_LOCK_EN
                // A locked owner keeps the bus while it still requests; otherwise the bus idles
                if (lock[sel_q]) begin
                    if (req[sel_q]) begin
                        state_d  = S_SETUP;
                        take     = 1'b1;
                        take_sel = sel_q;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else
`endif
                if (|req) begin
                    state_d = S_SETUP;
                    take    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction registers: winner's request is captured at grant, read data at the end of the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                sel_q   <= take_sel;
                last_q  <= take_sel;
                we_q    <= we[take_sel];
                io_q    <= io[take_sel];
                addr_q  <= take_sel ? addr1 : addr0;
                wdata_q <= take_sel ? wdata1 : wdata0;
            end
            if ((state_q == S_STROBE) && !we_q) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    // Outputs decoded from state only, so reset clears them without waiting for a clock edge
    always_comb begin
        logic [1:0] owner;
        owner   = sel_q ? 2'b10 : 2'b01;
        gnt     = 2'b00;
        done    = 2'b00;
        bus_ri  = 1'b0;
        bus_ro  = 1'b0;
        bus_io  = 1'b0;
        mem_clk = (state_q == S_STROBE);
        if (state_q != S_IDLE) begin
            gnt    = owner;
            bus_ri = we_q;
            bus_ro = !we_q;
            bus_io = io_q;
        end
        if (state_q == S_HOLD) begin
            done = owner;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req, we, io;
    logic [7:0] addr0, addr1, wdata0, wdata1, bus_rdata;
    logic [1:0] lock;
    logic [1:0] gnt, done;
    logic [7:0] rdata, bus_addr, bus_wdata;
    logic       bus_ri, bus_ro, bus_io, mem_clk;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .io        (io),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
`ifdef BUS_ARB_LOCK_EN
        .lock      (lock),
`endif
        .bus_rdata (bus_rdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ri    (bus_ri),
        .bus_ro    (bus_ro),
        .bus_io    (bus_io),
        .mem_clk   (mem_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req, we, io;
        logic [7:0] a0, a1, brd;
        logic [1:0] gnt, done;
        logic       mclk;
        logic [2:0] rrio;   // {bus_ri, bus_ro, bus_io}
        logic [7:0] addr, wdata, rdata;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic [1:0] r, logic [1:0] w, logic [1:0] i,
                                logic [7:0] a0, logic [7:0] a1, logic [7:0] brd,
                                logic [1:0] g, logic [1:0] d, logic m, logic [2:0] rrio,
                                logic [7:0] ad, logic [7:0] wd, logic [7:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.io = i; v.a0 = a0; v.a1 = a1; v.brd = brd;
        v.gnt = g; v.done = d; v.mclk = m; v.rrio = rrio;
        v.addr = ad; v.wdata = wd; v.rdata = rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs(string tag, logic [1:0] g, logic [1:0] d, logic m, logic [2:0] rrio,
                                 logic [7:0] ad, logic [7:0] wd, logic [7:0] rd);
        check({tag, " gnt"},     32'(gnt), 32'(g));
        check({tag, " done"},    32'(done), 32'(d));
        check({tag, " mem_clk"}, 32'(mem_clk), 32'(m));
        check({tag, " ri_ro_io"}, 32'({bus_ri, bus_ro, bus_io}), 32'(rrio));
        check({tag, " bus_addr"}, 32'(bus_addr), 32'(ad));
        check({tag, " bus_wdata"}, 32'(bus_wdata), 32'(wd));
        check({tag, " rdata"},   32'(rdata), 32'(rd));
    endtask

    initial begin
        // read of addr 10, I/O write of 42 to addr 00, three-way contention, early-dropped req[0]
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 3'b010, 8'h10, 8'h11, 8'h00);
        tbl[1]  = mk(2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 3'b010, 8'h10, 8'h11, 8'h00);
        tbl[2]  = mk(2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h5A, 2'b01, 2'b01, 1'b0, 3'b010, 8'h10, 8'h11, 8'h5A);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 3'b000, 8'h10, 8'h11, 8'h5A);
        tbl[4]  = mk(2'b10, 2'b10, 2'b10, 8'h10, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 3'b101, 8'h00, 8'h2A, 8'h5A);
        tbl[5]  = mk(2'b00, 2'b10, 2'b10, 8'h10, 8'h00, 8'h00, 2'b10, 2'b00, 1'b1, 3'b101, 8'h00, 8'h2A, 8'h5A);
        tbl[6]  = mk(2'b00, 2'b10, 2'b10, 8'h10, 8'h00, 8'hFF, 2'b10, 2'b10, 1'b0, 3'b101, 8'h00, 8'h2A, 8'h5A);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 3'b000, 8'h00, 8'h2A, 8'h5A);
        tbl[8]  = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b01, 2'b00, 1'b0, 3'b010, 8'hA0, 8'h11, 8'h5A);
        tbl[9]  = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b01, 2'b00, 1'b1, 3'b010, 8'hA0, 8'h11, 8'h5A);
        tbl[10] = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'hC3, 2'b01, 2'b01, 1'b0, 3'b010, 8'hA0, 8'h11, 8'hC3);
        tbl[11] = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b10, 2'b00, 1'b0, 3'b010, 8'hB1, 8'h2A, 8'hC3);
        tbl[12] = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b10, 2'b00, 1'b1, 3'b010, 8'hB1, 8'h2A, 8'hC3);
        tbl[13] = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'hD4, 2'b10, 2'b10, 1'b0, 3'b010, 8'hB1, 8'h2A, 8'hD4);
        tbl[14] = mk(2'b11, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b01, 2'b00, 1'b0, 3'b010, 8'hA0, 8'h11, 8'hD4);
        tbl[15] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b01, 2'b00, 1'b1, 3'b010, 8'hA0, 8'h11, 8'hD4);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'hE5, 2'b01, 2'b01, 1'b0, 3'b010, 8'hA0, 8'h11, 8'hE5);
        tbl[17] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'hB1, 8'h00, 2'b00, 2'b00, 1'b0, 3'b000, 8'hA0, 8'h11, 8'hE5);
        tbl[18] = mk(2'b10, 2'b00, 2'b00, 8'hA0, 8'h33, 8'h00, 2'b10, 2'b00, 1'b0, 3'b010, 8'h33, 8'h2A, 8'hE5);
        tbl[19] = mk(2'b01, 2'b00, 2'b00, 8'hA0, 8'h33, 8'h00, 2'b10, 2'b00, 1'b1, 3'b010, 8'h33, 8'h2A, 8'hE5);
        tbl[20] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'h33, 8'h77, 2'b10, 2'b10, 1'b0, 3'b010, 8'h33, 8'h2A, 8'h77);
        tbl[21] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'h33, 8'h00, 2'b00, 2'b00, 1'b0, 3'b000, 8'h33, 8'h2A, 8'h77);
        tbl[22] = mk(2'b00, 2'b00, 2'b00, 8'hA0, 8'h33, 8'h00, 2'b00, 2'b00, 1'b0, 3'b000, 8'h33, 8'h2A, 8'h77);

        reset = 1'b0;
        req = 2'b00; we = 2'b00; io = 2'b00; lock = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h11; wdata1 = 8'h2A; bus_rdata = 8'h00;
        cyc();
        cyc();
        check_outputs("in_reset", 2'b00, 2'b00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        cyc();
        check_outputs("after_reset", 2'b00, 2'b00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 23; i++) begin
            req = tbl[i].req; we = tbl[i].we; io = tbl[i].io;
            addr0 = tbl[i].a0; addr1 = tbl[i].a1; bus_rdata = tbl[i].brd;
            cyc();
            check_outputs($sformatf("row%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].mclk,
                          tbl[i].rrio, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            check($sformatf("row%0d ri_ro_exclusive", i), 32'(bus_ri & bus_ro), 32'd0);
        end

        // Reset asserted during STROBE clears everything without a clock edge
        req = 2'b01; addr0 = 8'h44; bus_rdata = 8'h99;
        cyc();
        req = 2'b00;
        cyc();
        check("pre_reset mem_clk", 32'(mem_clk), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async mem_clk", 32'(mem_clk), 32'd0);
        check("async gnt", 32'(gnt), 32'd0);
        check("async enables", 32'({bus_ri, bus_ro, bus_io}), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async bus_addr", 32'(bus_addr), 32'd0);
        check("async rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        cyc();
        check("held_reset done", 32'(done), 32'd0);
        reset = 1'b1;
        req = 2'b11; addr0 = 8'h55; addr1 = 8'h66;
        cyc();
        check("post_reset first gnt", 32'(gnt), 32'b01);
        check("post_reset addr", 32'(bus_addr), 32'h55);
        req = 2'b00;
        cyc();
        check("post_reset strobe done", 32'(done), 32'd0);
        cyc();
        check("post_reset hold done", 32'(done), 32'b01);
        check("post_reset rdata", 32'(rdata), 32'h99);
        cyc();
        check("post_reset idle gnt", 32'(gnt), 32'd0);

`ifdef BUS_ARB_LOCK_EN
        // Locked requester 0 keeps the bus until its lock drops, then requester 1 gets it
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        req = 2'b11; lock = 2'b01;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k < 3) ? 2'b01 : 2'b10;
            cyc();
            check($sformatf("lock xfer%0d gnt", k), 32'(gnt), 32'(exp_g));
            cyc();
            if (k == 2) lock = 2'b00;
            if (k == 3) req = 2'b00;
            cyc();
            check($sformatf("lock xfer%0d done", k), 32'(done), 32'(exp_g));
        end
        cyc();
        check("lock final idle gnt", 32'(gnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
